lcd_ks0108_responder: RTL and testbench
=======================================

LCD_KS0108_RESPONDER -- requirements
Module: lcd_ks0108_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on LCD_ENABLE.
REQ-002 SHALL have port clk, input, 1 bit: single system clock, rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports LCD_ENABLE, LCD_RW, LCD_DI, LCD_CS1, LCD_CS2, LCD_RST, inputs, 1 bit each: the panel bus driven by the LCD transmitter. CS1 and CS2 are active-high; LCD_RST is active-low.
REQ-005 SHALL have port LCD_DATA_IN, input, 8 bits: write data and commands from the transmitter.
REQ-006 SHALL have port LCD_DATA_OUT, output, 8 bits: read data or status returned to the transmitter.
REQ-007 SHALL have port LCD_DATA_OE, output, 1 bit: high while the responder drives the data bus.
REQ-008 SHALL have ports q_chip (1), q_page (3), q_col (6), inputs: backdoor address, where chip 0 is the CS1 half.
REQ-009 SHALL have port q_data, output, 8 bits: backdoor RAM byte, registered.
REQ-010 SHALL have ports disp_on (1), start_line (2x6, {cs2,cs1}), illegal_cmd (1, sticky), outputs.

Function
REQ-011 SHALL pass LCD_ENABLE through SYNC_STAGES flops. A falling edge is detected as previous=1, current=0; a rising edge as previous=0, current=1.
REQ-012 SHALL sample RW, DI, CS1, CS2 and DATA_IN in the detect cycle. The transmitter guarantees these are stable for at least SYNC_STAGES+1 clk cycles before the enable falls.
REQ-013 SHALL update state at the clk edge that ends the detect cycle, so the effect is visible one cycle later.
REQ-014 SHALL apply an action to every half whose CS is high. With neither CS high, the access is ignored with no state change and OE stays low.
REQ-015 SHALL decode a falling edge with DI=0, RW=0 as a command:
- 0x3E/0x3F: display off/on.
- 0x40|y: Y address := y.
- 0xB8|p: page := p.
- 0xC0|z: start line := z.
- Any other code sets illegal_cmd and has no other effect.
REQ-016 SHALL, on DI=1, RW=0, write DATA_IN to RAM[page][Y] and then set Y := (Y+1) mod 64. 63 wraps to 0 and the page is unchanged.
REQ-017 SHALL, on a rising edge with RW=1 and a CS high, assert OE and drive OUT starting the next cycle until a falling edge is detected. OE falls in the cycle after detection.
REQ-018 SHALL drive status when DI=0: {busy=0, 0, ~disp_on, reset_flag, 4'b0000}. reset_flag is high while LCD_RST is low.
REQ-019 SHALL drive RAM[page][Y] when DI=1 and increment Y mod 64 on the falling edge. There is no dummy read.
REQ-020 SHALL, for reads with both CS high, return the CS1 half; Y increments in both halves.
REQ-021 SHALL, while LCD_RST is low, ignore bus accesses except status reads and hold display off, Y=0, page=0, start line=0. RAM is retained.
REQ-022 SHALL present q_data = RAM[q_chip][q_page][q_col] one cycle after the address is applied, independent of bus traffic. A same-cycle write is shown on the following cycle.
REQ-023 SHALL implement RAM as 2x512x8 synchronous storage, one write port per half.

Reset
REQ-024 SHALL, on rst high, immediately set: disp_on=0, Y=0, page=0, start lines=0, illegal_cmd=0, OE=0, OUT=0x00, q_data=0x00, synchronizer flops=0.
REQ-025 SHALL leave RAM contents undefined after rst.
REQ-026 SHALL, when rst is asserted mid-read, drop OE asynchronously.
REQ-027 SHALL, after rst deasserts with LCD_ENABLE high, not treat the first sampled high as a rising edge.

Verification
REQ-028 SHALL cover: CS1=1, commands 0xB8|3, 0x40|10, data 0xA5 -> q(0,3,10)=0xA5; next write 0x5A lands at column 11.
REQ-029 SHALL cover: Y=63, write 0x11 then 0x22 -> (page,63)=0x11, (page,0)=0x22, page unchanged.
REQ-030 SHALL cover: CS1=CS2=1, write 0xFF at page 0 col 0 -> both halves hold 0xFF; a status read with display on returns 0x00.
REQ-031 SHALL cover: command 0x3F then a status read -> OUT=0x00; command 0x3E -> status reads 0x20; LCD_RST low -> status reads 0x30.
REQ-032 SHALL cover: command 0x12 -> illegal_cmd=1 and stays high; a subsequent rst clears it.
REQ-033 SHALL cover: neither CS high, write 0x77 -> RAM unchanged and OE never asserted; rst asserted during a read -> OE=0 in the same cycle.

Source files
------------

// File: rtl/lcd_ks0108_responder.sv
// lcd_ks0108_responder: KS0108-style dual-half panel model answering an LCD transmitter bus.
module lcd_ks0108_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             LCD_ENABLE,
  input  logic             LCD_RW,
  input  logic             LCD_DI,
  input  logic             LCD_CS1,
  input  logic             LCD_CS2,
  input  logic             LCD_RST,
  input  logic [7:0]       LCD_DATA_IN,
  output logic [7:0]       LCD_DATA_OUT,
  output logic             LCD_DATA_OE,
  input  logic             q_chip,
  input  logic [2:0]       q_page,
  input  logic [5:0]       q_col,
  output logic [7:0]       q_data,
  output logic             disp_on,
  output logic [1:0][5:0]  start_line,
  output logic             illegal_cmd
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   vld_q;
  logic                   prev_q, en_s, rise, fall, cmd, dat;
  logic                   is_disp, is_y, is_pg, is_st;
  logic [1:0]             cs, we;
  logic [1:0][5:0]        y_q, y_d, start_q, start_d;
  logic [1:0][2:0]        page_q, page_d;
  logic                   disp_q, disp_d, ill_q, ill_d, oe_q, oe_d;
  logic                   rdi_q, rdi_d, rc1_q, rc1_d;
  logic [7:0]             out_q, out_d, qd_q, ram_rd, status;
  logic [7:0]             mem0 [512];
  logic [7:0]             mem1 [512];

  assign en_s = sync_q[SYNC_STAGES-1];
  // Edges only count once the previous-sample register holds a real post-reset sample.
  assign rise = vld_q[SYNC_STAGES] & ~prev_q & en_s;
  assign fall = vld_q[SYNC_STAGES] & prev_q & ~en_s;
  assign cs = {LCD_CS2, LCD_CS1};
  assign cmd = fall & |cs & LCD_RST & ~LCD_DI & ~LCD_RW;
  assign dat = fall & |cs & LCD_RST & LCD_DI;
  assign is_disp = LCD_DATA_IN[7:1] == 7'b0011111;
  assign is_y = LCD_DATA_IN[7:6] == 2'b01;
  assign is_pg = LCD_DATA_IN[7:3] == 5'b10111;
  assign is_st = LCD_DATA_IN[7:6] == 2'b11;
  assign status = {2'b00, ~disp_q, ~LCD_RST, 4'b0000};

  always_comb begin
    y_d = y_q;
    page_d = page_q;
    start_d = start_q;
    disp_d = (cmd && is_disp) ? LCD_DATA_IN[0] : disp_q;
    ill_d = ill_q | (cmd & ~(is_disp | is_y | is_pg | is_st));
    oe_d = fall ? 1'b0 : oe_q;
    rdi_d = rdi_q;
    rc1_d = rc1_q;
    we = '0;
    if (rise && LCD_RW && |cs && (LCD_RST || !LCD_DI)) begin
      oe_d = 1'b1;
      rdi_d = LCD_DI;
      rc1_d = LCD_CS1;
    end
    for (int i = 0; i < 2; i++) begin
      if (cs[i]) begin
        y_d[i] = (cmd && is_y) ? LCD_DATA_IN[5:0] : dat ? y_q[i] + 6'd1 : y_q[i];
        page_d[i] = (cmd && is_pg) ? LCD_DATA_IN[2:0] : page_q[i];
        start_d[i] = (cmd && is_st) ? LCD_DATA_IN[5:0] : start_q[i];
        we[i] = dat & ~LCD_RW;
      end
    end
    if (!LCD_RST) begin
      disp_d = 1'b0;
      y_d = '0;
      page_d = '0;
      start_d = '0;
    end
    ram_rd = rc1_d ? mem0[{page_q[0], y_q[0]}] : mem1[{page_q[1], y_q[1]}];
    out_d = oe_d ? (rdi_d ? ram_rd : status) : out_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      vld_q <= '0;
      prev_q <= 1'b0;
      y_q <= '0;
      page_q <= '0;
      start_q <= '0;
      disp_q <= 1'b0;
      ill_q <= 1'b0;
      oe_q <= 1'b0;
      rdi_q <= 1'b0;
      rc1_q <= 1'b0;
      out_q <= '0;
      qd_q <= '0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(LCD_ENABLE);
      vld_q <= {vld_q[SYNC_STAGES-1:0], 1'b1};
      prev_q <= en_s;
      y_q <= y_d;
      page_q <= page_d;
      start_q <= start_d;
      disp_q <= disp_d;
      ill_q <= ill_d;
      oe_q <= oe_d;
      rdi_q <= rdi_d;
      rc1_q <= rc1_d;
      out_q <= out_d;
      qd_q <= q_chip ? mem1[{q_page, q_col}] : mem0[{q_page, q_col}];
    end
  end

  always_ff @(posedge clk) begin
    if (we[0]) mem0[{page_q[0], y_q[0]}] <= LCD_DATA_IN;
    if (we[1]) mem1[{page_q[1], y_q[1]}] <= LCD_DATA_IN;
  end

  assign LCD_DATA_OUT = out_q;
  assign LCD_DATA_OE = oe_q;
  assign q_data = qd_q;
  assign disp_on = disp_q;
  assign start_line = start_q;
  assign illegal_cmd = ill_q;
endmodule

// File: tb/tb_lcd_ks0108_responder.sv
// tb_lcd_ks0108_responder: directed and randomized bus transactions against a panel reference model.
module tb_lcd_ks0108_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, rw = 1'b0, di = 1'b0, c1 = 1'b0, c2 = 1'b0, lrst = 1'b1;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic oe;
  logic qc = 1'b0;
  logic [2:0] qp = '0;
  logic [5:0] qcol = '0;
  logic [7:0] qd;
  logic disp;
  logic [1:0][5:0] sl;
  logic ill;
  int n_cmp = 0, n_bad = 0;

  bit [7:0] m_mem[2][512];
  bit m_known[2][512];
  int m_y[2], m_pg[2], m_st[2];
  bit m_disp, m_ill;

  lcd_ks0108_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .LCD_ENABLE(en), .LCD_RW(rw), .LCD_DI(di),
    .LCD_CS1(c1), .LCD_CS2(c2), .LCD_RST(lrst), .LCD_DATA_IN(din),
    .LCD_DATA_OUT(dout), .LCD_DATA_OE(oe), .q_chip(qc), .q_page(qp),
    .q_col(qcol), .q_data(qd), .disp_on(disp), .start_line(sl), .illegal_cmd(ill)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic model_clear();
    m_disp = 0; m_ill = 0;
    for (int k = 0; k < 2; k++) begin
      m_y[k] = 0; m_pg[k] = 0; m_st[k] = 0;
      for (int a = 0; a < 512; a++) m_known[k][a] = 0;
    end
  endtask

  task automatic model_panel_reset();
    m_disp = 0;
    for (int k = 0; k < 2; k++) begin m_y[k] = 0; m_pg[k] = 0; m_st[k] = 0; end
  endtask

  // Reference model: computes the expected read result, then applies the access.
  task automatic ref_model(input bit r, i, a, b, input logic [7:0] d,
                           output bit eo, output logic [7:0] er, output bit ek);
    bit sel[2];
    int h;
    sel[0] = a; sel[1] = b;
    h = a ? 0 : 1;
    eo = r && (a || b) && (lrst || !i);
    ek = !i || m_known[h][m_pg[h] * 64 + m_y[h]];
    er = i ? m_mem[h][m_pg[h] * 64 + m_y[h]] : {2'b00, !m_disp, !lrst, 4'b0000};
    if ((a || b) && lrst) begin
      if (!i && !r) begin
        if (d == 8'h3E || d == 8'h3F) m_disp = d[0];
        else if (d >= 8'h40 && d <= 8'h7F) begin for (int k = 0; k < 2; k++) if (sel[k]) m_y[k] = d - 8'h40; end
        else if (d >= 8'hB8 && d <= 8'hBF) begin for (int k = 0; k < 2; k++) if (sel[k]) m_pg[k] = d - 8'hB8; end
        else if (d >= 8'hC0) begin for (int k = 0; k < 2; k++) if (sel[k]) m_st[k] = d - 8'hC0; end
        else m_ill = 1;
      end else if (i) begin
        for (int k = 0; k < 2; k++) if (sel[k]) begin
          if (!r) begin m_mem[k][m_pg[k] * 64 + m_y[k]] = d; m_known[k][m_pg[k] * 64 + m_y[k]] = 1; end
          m_y[k] = (m_y[k] + 1) % 64;
        end
      end
    end
  endtask

  // One full enable pulse; returns OE/OUT seen late in the high phase and OE after the low phase.
  task automatic xfer(input bit r, i, a, b, input logic [7:0] d, output logic [7:0] rd,
                      output logic oh, output logic oa, output bit eo, output logic [7:0] er, output bit ek);
    ref_model(r, i, a, b, d, eo, er, ek);
    @(negedge clk);
    rw = r; di = i; c1 = a; c2 = b; din = d; en = 1'b1;
    repeat (6) @(negedge clk);
    oh = oe; rd = dout; en = 1'b0;
    repeat (6) @(negedge clk);
    oa = oe;
  endtask

  task automatic peek(input bit c, input int p, input int col, output logic [7:0] v);
    @(negedge clk);
    qc = c; qp = p[2:0]; qcol = col[5:0];
    @(negedge clk);
    v = qd;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe got %b want 0", oe); end
    n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL reset_out got %h want 00", dout); end
    n_cmp++; if (qd !== 8'h00) begin n_bad++; $display("FAIL reset_qdata got %h want 00", qd); end
    n_cmp++; if (disp !== 1'b0) begin n_bad++; $display("FAIL reset_disp got %b want 0", disp); end
    n_cmp++; if (sl !== 12'h000) begin n_bad++; $display("FAIL reset_start got %h want 000", sl); end
    n_cmp++; if (ill !== 1'b0) begin n_bad++; $display("FAIL reset_ill got %b want 0", ill); end
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_cmd_write();
    logic [7:0] rd, er, v; logic oh, oa; bit eo, ek;
    xfer(0, 0, 1, 0, 8'hBB, rd, oh, oa, eo, er, ek);
    xfer(0, 0, 1, 0, 8'h4A, rd, oh, oa, eo, er, ek);
    xfer(0, 1, 1, 0, 8'hA5, rd, oh, oa, eo, er, ek);
    peek(0, 3, 10, v);
    n_cmp++; if (v !== 8'hA5) begin n_bad++; $display("FAIL wr_0_3_10 got %h want a5", v); end
    xfer(0, 1, 1, 0, 8'h5A, rd, oh, oa, eo, er, ek);
    peek(0, 3, 11, v);
    n_cmp++; if (v !== 8'h5A) begin n_bad++; $display("FAIL wr_0_3_11 got %h want 5a", v); end
    n_cmp++; if (oh !== 1'b0) begin n_bad++; $display("FAIL wr_no_oe got %b want 0", oh); end
    xfer(0, 1, 1, 0, 8'h66, rd, oh, oa, eo, er, ek);
    xfer(0, 0, 1, 0, 8'h4C, rd, oh, oa, eo, er, ek);
  endtask

  task automatic test_no_cs();
    logic [7:0] rd, er, v; logic oh, oa; bit eo, ek;
    xfer(0, 1, 0, 0, 8'h77, rd, oh, oa, eo, er, ek);
    n_cmp++; if (oh !== 1'b0) begin n_bad++; $display("FAIL nocs_wr_oe got %b want 0", oh); end
    peek(0, 3, 12, v);
    n_cmp++; if (v !== 8'h66) begin n_bad++; $display("FAIL nocs_ram got %h want 66", v); end
    xfer(1, 1, 0, 0, 8'h00, rd, oh, oa, eo, er, ek);
    n_cmp++; if (oh !== 1'b0) begin n_bad++; $display("FAIL nocs_rd_oe got %b want 0", oh); end
    xfer(1, 1, 1, 0, 8'h00, rd, oh, oa, eo, er, ek);
    n_cmp++; if (oh !== 1'b1) begin n_bad++; $display("FAIL rd_oe got %b want 1", oh); end
    n_cmp++; if (rd !== 8'h66) begin n_bad++; $display("FAIL rd_data got %h want 66", rd); end
    n_cmp++; if (oa !== 1'b0) begin n_bad++; $display("FAIL rd_oe_drop got %b want 0", oa); end
  endtask

  task automatic test_wrap();
    logic [7:0] rd, er, v; logic oh, oa; bit eo, ek;
    xfer(0, 0, 1, 0, 8'hBD, rd, oh, oa, eo, er, ek);
    xfer(0, 0, 1, 0, 8'h7F, rd, oh, oa, eo, er, ek);
    xfer(0, 1, 1, 0, 8'h11, rd, oh, oa, eo, er, ek);
    xfer(0, 1, 1, 0, 8'h22, rd, oh, oa, eo, er, ek);
    xfer(0, 1, 1, 0, 8'h33, rd, oh, oa, eo, er, ek);
    peek(0, 5, 63, v);
    n_cmp++; if (v !== 8'h11) begin n_bad++; $display("FAIL wrap_63 got %h want 11", v); end
    peek(0, 5, 0, v);
    n_cmp++; if (v !== 8'h22) begin n_bad++; $display("FAIL wrap_0 got %h want 22", v); end
    peek(0, 5, 1, v);
    n_cmp++; if (v !== 8'h33) begin n_bad++; $display("FAIL wrap_page got %h want 33", v); end
  endtask

  task automatic test_both_cs();
    logic [7:0] rd, er, v; logic oh, oa; bit eo, ek;
    xfer(0, 0, 1, 1, 8'h3F, rd, oh, oa, eo, er, ek);
    xfer(0, 0, 1, 1, 8'hB8, rd, oh, oa, eo, er, ek);
    xfer(0, 0, 1, 1, 8'h40, rd, oh, oa, eo, er, ek);
    xfer(0, 1, 1, 1, 8'hFF, rd, oh, oa, eo, er, ek);
    peek(0, 0, 0, v);
    n_cmp++; if (v !== 8'hFF) begin n_bad++; $display("FAIL both_cs1 got %h want ff", v); end
    peek(1, 0, 0, v);
    n_cmp++; if (v !== 8'hFF) begin n_bad++; $display("FAIL both_cs2 got %h want ff", v); end
    xfer(1, 0, 1, 1, 8'h00, rd, oh, oa, eo, er, ek);
    n_cmp++; if (rd !== 8'h00 || oh !== 1'b1) begin n_bad++; $display("FAIL both_status got %h oe %b want 00 oe 1", rd, oh); end
    xfer(0, 0, 0, 1, 8'hD5, rd, oh, oa, eo, er, ek);
    n_cmp++; if (sl !== {6'd21, 6'd0}) begin n_bad++; $display("FAIL start_line got %h want %h", sl, {6'd21, 6'd0}); end
  endtask

  task automatic test_status();
    logic [7:0] rd, er; logic oh, oa; bit eo, ek;
    xfer(0, 0, 1, 0, 8'h3F, rd, oh, oa, eo, er, ek);
    xfer(1, 0, 1, 0, 8'h00, rd, oh, oa, eo, er, ek);
    n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL status_on got %h want 00", rd); end
    xfer(0, 0, 1, 0, 8'h3E, rd, oh, oa, eo, er, ek);
    xfer(1, 0, 1, 0, 8'h00, rd, oh, oa, eo, er, ek);
    n_cmp++; if (rd !== 8'h20) begin n_bad++; $display("FAIL status_off got %h want 20", rd); end
    xfer(0, 0, 1, 1, 8'h3F, rd, oh, oa, eo, er, ek);
    @(negedge clk); lrst = 1'b0; model_panel_reset();
    xfer(1, 0, 1, 0, 8'h00, rd, oh, oa, eo, er, ek);
    n_cmp++; if (rd !== 8'h30) begin n_bad++; $display("FAIL status_rst got %h want 30", rd); end
    n_cmp++; if (disp !== 1'b0 || sl !== 12'h000) begin n_bad++; $display("FAIL lrst_hold got disp %b start %h want 0 000", disp, sl); end
    xfer(1, 1, 1, 0, 8'h00, rd, oh, oa, eo, er, ek);
    n_cmp++; if (oh !== 1'b0) begin n_bad++; $display("FAIL lrst_data_rd_oe got %b want 0", oh); end
    @(negedge clk); lrst = 1'b1;
  endtask

  task automatic test_illegal();
    logic [7:0] rd, er; logic oh, oa; bit eo, ek;
    n_cmp++; if (ill !== 1'b0) begin n_bad++; $display("FAIL ill_pre got %b want 0", ill); end
    xfer(0, 0, 1, 0, 8'h12, rd, oh, oa, eo, er, ek);
    n_cmp++; if (ill !== 1'b1) begin n_bad++; $display("FAIL ill_set got %b want 1", ill); end
    xfer(0, 0, 1, 0, 8'h3F, rd, oh, oa, eo, er, ek);
    n_cmp++; if (ill !== 1'b1) begin n_bad++; $display("FAIL ill_sticky got %b want 1", ill); end
    do_reset();
    n_cmp++; if (ill !== 1'b0) begin n_bad++; $display("FAIL ill_clear got %b want 0", ill); end
  endtask

  task automatic test_rst_mid_read();
    logic [7:0] rd, er; logic oh, oa; bit eo, ek;
    int t;
    @(negedge clk);
    rw = 1'b1; di = 1'b0; c1 = 1'b1; c2 = 1'b0; en = 1'b1;
    t = 0;
    while (oe !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    n_cmp++; if (oe !== 1'b1) begin n_bad++; $display("FAIL mid_read_oe timeout got %b want 1", oe); end
    @(posedge clk); #2 rst = 1'b1;
    #1;
    n_cmp++; if (oe !== 1'b0) begin n_bad++; $display("FAIL async_oe got %b want 0", oe); end
    n_cmp++; if (dout !== 8'h00) begin n_bad++; $display("FAIL async_out got %h want 00", dout); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_clear();
    repeat (8) @(negedge clk);
    n_cmp++; if (oe !== 1'b0) begin n_bad++; $display("FAIL no_false_rise got %b want 0", oe); end
    en = 1'b0;
    repeat (6) @(negedge clk);
    xfer(1, 0, 1, 0, 8'h00, rd, oh, oa, eo, er, ek);
    n_cmp++; if (oh !== 1'b1 || rd !== 8'h20) begin n_bad++; $display("FAIL post_rst_status got %h oe %b want 20 oe 1", rd, oh); end
  endtask

  task automatic test_random();
    logic [7:0] rd, er, v, d; logic oh, oa; bit eo, ek, r, i, a, b;
    int kind, p, col, h;
    for (int k = 0; k < 2; k++)
      for (int pg = 0; pg < 2; pg++) begin
        xfer(0, 0, k == 0, k == 1, 8'hB8 | 8'(pg), rd, oh, oa, eo, er, ek);
        xfer(0, 0, k == 0, k == 1, 8'h40, rd, oh, oa, eo, er, ek);
        for (int c = 0; c < 64; c++) xfer(0, 1, k == 0, k == 1, 8'($urandom), rd, oh, oa, eo, er, ek);
      end
    for (int n = 0; n < 200; n++) begin
      if ($urandom % 20 == 0) begin
        @(negedge clk); lrst = ~lrst;
        if (!lrst) model_panel_reset();
      end
      kind = $urandom % 8;
      a = 1'($urandom); b = 1'($urandom);
      if (kind < 3) begin
        r = 0; i = 0;
        case ($urandom % 5)
          0: d = 8'h3E | 8'($urandom % 2);
          1: d = 8'h40 | 8'($urandom % 64);
          2: d = 8'hB8 | 8'($urandom % 2);
          3: d = 8'hC0 | 8'($urandom % 64);
          default: d = 8'($urandom);
        endcase
      end else if (kind < 6) begin r = 0; i = 1; d = 8'($urandom); end
      else begin r = 1; i = 1'($urandom); d = 8'($urandom); end
      xfer(r, i, a, b, d, rd, oh, oa, eo, er, ek);
      n_cmp++; if (oh !== eo) begin n_bad++; $display("FAIL rnd_oe n=%0d got %b want %b", n, oh, eo); end
      if (eo && ek) begin
        n_cmp++; if (rd !== er) begin n_bad++; $display("FAIL rnd_rdata n=%0d got %h want %h", n, rd, er); end
      end
      n_cmp++; if (oa !== 1'b0) begin n_bad++; $display("FAIL rnd_oe_drop n=%0d got %b want 0", n, oa); end
      n_cmp++; if (disp !== m_disp) begin n_bad++; $display("FAIL rnd_disp n=%0d got %b want %b", n, disp, m_disp); end
      n_cmp++; if (sl !== {6'(m_st[1]), 6'(m_st[0])}) begin n_bad++; $display("FAIL rnd_start n=%0d got %h want %h", n, sl, {6'(m_st[1]), 6'(m_st[0])}); end
      n_cmp++; if (ill !== m_ill) begin n_bad++; $display("FAIL rnd_ill n=%0d got %b want %b", n, ill, m_ill); end
      if (n % 8 == 0) begin
        h = $urandom % 2; p = $urandom % 2; col = $urandom % 64;
        peek(h[0], p, col, v);
        if (m_known[h][p * 64 + col]) begin
          n_cmp++; if (v !== m_mem[h][p * 64 + col]) begin n_bad++; $display("FAIL rnd_peek %0d/%0d/%0d got %h want %h", h, p, col, v, m_mem[h][p * 64 + col]); end
        end
      end
    end
    @(negedge clk); lrst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_cmd_write();
    test_no_cs();
    test_wrap();
    test_both_cs();
    test_status();
    test_illegal();
    test_rst_mid_read();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
